// File: rtl/apb_accum_pkg.sv
// Shared types, register offsets and bit positions for the APB accumulator.
// Used by apb_accum_ch and apb_accum_multi (macro APB_ACC_SAT_EN lives there).
package apb_accum_pkg;

    typedef enum logic [1:0] {
        OP_OR  = 2'b00,
        OP_AND = 2'b01,
        OP_XOR = 2'b10,
        OP_ADD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS
    } apb_st_e;

    localparam logic [3:0] OFF_DATA = 4'h0;
    localparam logic [3:0] OFF_CTRL = 4'h4;
    localparam logic [3:0] OFF_RES  = 4'h8;
    localparam logic [3:0] OFF_STAT = 4'hC;

    localparam int CH_STRIDE = 'h10;
    localparam int CH_SHIFT  = $clog2(CH_STRIDE);

    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;
    localparam int CTRL_OP_LO = 2;
    localparam int CTRL_OP_HI = 3;

    localparam int STAT_BUSY = 0;
    localparam int STAT_OVF  = 1;

endpackage

// File: rtl/apb_accum_ch.sv
// One accumulator channel: DATA/OP/RESULT/STATUS, latency counter, ALU, done.
// APB_ACC_SAT_EN: ADD saturates at all-ones on carry-out instead of wrapping.
module apb_accum_ch
    import apb_accum_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_data,
    input  logic              wr_ctrl,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] data,
    output op_e               op,
    output logic [DATA_W-1:0] result,
    output logic              busy,
    output logic              ovf,
    output logic              done
);

    localparam int CW = (OP_LAT > 1) ? $clog2(OP_LAT) : 1;

    logic [DATA_W-1:0] opnd;
    op_e               lat_op;
    logic [CW-1:0]     cnt;
    logic              start;
    logic              clear;
    logic              fire;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] nxt;
    logic              carry;

    assign clear = wr_ctrl & wdata[CTRL_CLEAR];
    assign start = wr_ctrl & wdata[CTRL_START] & ~wdata[CTRL_CLEAR];
    assign fire  = busy & (cnt == '0);

    // ALU: next RESULT from the latched operand and operation
    always_comb begin
        sum   = {1'b0, result} + {1'b0, opnd};
        carry = 1'b0;
        nxt   = result;
        unique case (lat_op)
            OP_OR:  nxt = result | opnd;
            OP_AND: nxt = result & opnd;
            OP_XOR: nxt = result ^ opnd;
            OP_ADD: begin
                carry = sum[DATA_W];
`ifdef APB_ACC_SAT_EN
                nxt = carry ? '1 : sum[DATA_W-1:0];
`else
                nxt = sum[DATA_W-1:0];
`endif
            end
        endcase
    end

    // Channel registers; CLEAR wins over START, the op runs off latched copies
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data   <= '0;
            op     <= OP_OR;
            result <= '0;
            busy   <= 1'b0;
            ovf    <= 1'b0;
            done   <= 1'b0;
            opnd   <= '0;
            lat_op <= OP_OR;
            cnt    <= '0;
        end else begin
            done <= fire;
            if (wr_data) data <= wdata;
            if (wr_ctrl) op <= op_e'(wdata[CTRL_OP_HI:CTRL_OP_LO]);
            if (clear) begin
                result <= '0;
                ovf    <= 1'b0;
            end else if (start) begin
                opnd   <= data;
                lat_op <= op_e'(wdata[CTRL_OP_HI:CTRL_OP_LO]);
                busy   <= 1'b1;
                cnt    <= CW'(OP_LAT - 1);
            end else if (busy) begin
                if (fire) begin
                    result <= nxt;
                    busy   <= 1'b0;
                    if (carry) ovf <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/apb_accum_multi.sv
// Multi-channel APB accumulator: APB FSM, decode, error response, read mux.
// APB_ACC_SAT_EN selects saturating ADD inside every channel.
module apb_accum_multi
    import apb_accum_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int NUM_CH = 4,
    parameter int OP_LAT = 2
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [NUM_CH-1:0] done_o
);

    localparam int CHW = ADDR_W - CH_SHIFT;

    apb_st_e           state;
    apb_st_e           state_d;
    logic [CHW-1:0]    ch;
    logic [3:0]        off;
    logic              access;
    logic              err;
    logic              stall;
    logic              complete;
    logic              wr;
    logic [NUM_CH-1:0] wr_data;
    logic [NUM_CH-1:0] wr_ctrl;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] ovf;
    logic [DATA_W-1:0] data   [NUM_CH];
    logic [DATA_W-1:0] result [NUM_CH];
    op_e               op     [NUM_CH];
    logic [DATA_W-1:0] sel_data;
    logic [DATA_W-1:0] sel_res;
    logic [DATA_W-1:0] ctrl_rd;
    logic [DATA_W-1:0] stat_rd;
    logic              sel_busy;

    assign ch  = PADDR[ADDR_W-1:CH_SHIFT];
    assign off = PADDR[CH_SHIFT-1:0];

    // An access phase only counts once a setup phase has been seen
    assign access = PSEL & PENABLE & (state != S_IDLE);

    assign err = (int'(ch) >= NUM_CH)
               | (PADDR[1:0] != 2'b00)
               | (PWRITE & ((off == OFF_RES) | (off == OFF_STAT)));

    assign stall = access & ~err & sel_busy
                 & ((off == OFF_CTRL) | (off == OFF_RES));

    assign complete = access & ~stall;
    assign wr       = complete & PWRITE & ~err;
    assign PREADY   = ~stall;
    assign PSLVERR  = access & err;

    // APB phase register
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= S_IDLE;
        else          state <= state_d;
    end

    // APB next phase; stays in ACCESS while a busy channel holds PREADY low
    always_comb begin
        state_d = S_IDLE;
        unique case (state)
            S_IDLE: begin
                if (PSEL && !PENABLE) state_d = S_SETUP;
            end
            S_SETUP, S_ACCESS: begin
                if (PSEL && PENABLE) begin
                    state_d = stall ? S_ACCESS : S_IDLE;
                end else if (PSEL) begin
                    state_d = S_SETUP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pick the addressed channel's registers
    always_comb begin
        sel_data = '0;
        sel_res  = '0;
        ctrl_rd  = '0;
        stat_rd  = '0;
        sel_busy = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(ch) == c) begin
                sel_data = data[c];
                sel_res  = result[c];
                sel_busy = busy[c];
                ctrl_rd[CTRL_OP_HI:CTRL_OP_LO] = op[c];
                stat_rd[STAT_BUSY] = busy[c];
                stat_rd[STAT_OVF]  = ovf[c];
            end
        end
    end

    // Per-channel write strobes on the completing edge
    always_comb begin
        wr_data = '0;
        wr_ctrl = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(ch) == c) begin
                wr_data[c] = wr & (off == OFF_DATA);
                wr_ctrl[c] = wr & (off == OFF_CTRL);
            end
        end
    end

    // Read data, zero outside a good completing read
    always_comb begin
        PRDATA = '0;
        if (complete && !PWRITE && !err) begin
            case (off)
                OFF_DATA: PRDATA = sel_data;
                OFF_CTRL: PRDATA = ctrl_rd;
                OFF_RES:  PRDATA = sel_res;
                OFF_STAT: PRDATA = stat_rd;
                default:  PRDATA = '0;
            endcase
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        apb_accum_ch #(
            .DATA_W(DATA_W),
            .OP_LAT(OP_LAT)
        ) u_ch (
            .clk    (PCLK),
            .rst_n  (PRESETn),
            .wr_data(wr_data[c]),
            .wr_ctrl(wr_ctrl[c]),
            .wdata  (PWDATA),
            .data   (data[c]),
            .op     (op[c]),
            .result (result[c]),
            .busy   (busy[c]),
            .ovf    (ovf[c]),
            .done   (done_o[c])
        );
    end

endmodule

// File: tb/tb_apb_accum_multi.sv
// Directed bench for apb_accum_multi (4 channels, OP_LAT=2).
// Honours APB_ACC_SAT_EN for the ADD expectation.
module tb_apb_accum_multi;

    logic        PCLK;
    logic        PRESETn;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [3:0]  done_o;

    int errors = 0;
    int checks = 0;

    logic [31:0] r_data;
    logic        r_err;
    int          r_waits;

    int dcnt [4] = '{0, 0, 0, 0};

    apb_accum_multi #(
        .DATA_W(32),
        .ADDR_W(8),
        .NUM_CH(4),
        .OP_LAT(2)
    ) dut (
        .PCLK   (PCLK),
        .PRESETn(PRESETn),
        .PSEL   (PSEL),
        .PENABLE(PENABLE),
        .PWRITE (PWRITE),
        .PADDR  (PADDR),
        .PWDATA (PWDATA),
        .PRDATA (PRDATA),
        .PREADY (PREADY),
        .PSLVERR(PSLVERR),
        .done_o (done_o)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    always @(negedge PCLK) begin
        for (int c = 0; c < 4; c++)
            if (done_o[c] === 1'b1) dcnt[c] <= dcnt[c] + 1;
    end

    // Entered 1 time unit after a rising edge; leaves the same way
    task automatic xfer(input logic w, input logic [7:0] a,
                        input logic [31:0] d);
        int n;
        PSEL = 1'b1;
        PENABLE = 1'b0;
        PWRITE = w;
        PADDR = a;
        PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        n = 0;
        @(negedge PCLK);
        while (PREADY !== 1'b1 && n < 50) begin
            n++;
            @(negedge PCLK);
        end
        r_data = PRDATA;
        r_err = PSLVERR;
        r_waits = n;
        checks++;
        if (PREADY !== 1'b1) begin
            errors++;
            $display("FAIL timeout addr=%h: PREADY still %b", a, PREADY);
        end
        @(posedge PCLK); #1;
        PSEL = 1'b0;
        PENABLE = 1'b0;
    endtask

    task automatic test_reset;
        PRESETn = 1'b0;
        PSEL = 1'b0;
        PENABLE = 1'b0;
        PWRITE = 1'b0;
        PADDR = '0;
        PWDATA = '0;
        repeat (3) @(posedge PCLK);
        #1;
        checks++;
        if (PREADY !== 1'b1) begin
            errors++; $display("FAIL rst_pready: got %b want 1", PREADY);
        end
        checks++;
        if (PSLVERR !== 1'b0) begin
            errors++; $display("FAIL rst_pslverr: got %b want 0", PSLVERR);
        end
        checks++;
        if (PRDATA !== 32'h0) begin
            errors++; $display("FAIL rst_prdata: got %h want 0", PRDATA);
        end
        checks++;
        if (done_o !== 4'h0) begin
            errors++; $display("FAIL rst_done: got %h want 0", done_o);
        end
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        for (int i = 0; i < 4; i++) begin
            xfer(1'b0, 8'(i * 4), 32'h0);
            checks++;
            if (r_data !== 32'h0 || r_err !== 1'b0) begin
                errors++;
                $display("FAIL rst_read%0d: got %h err %b want 0 err 0",
                         i, r_data, r_err);
            end
        end
    endtask

    task automatic test_or;
        int d0;
        d0 = dcnt[0];
        xfer(1'b1, 8'h00, 32'h0C);
        xfer(1'b1, 8'h04, 32'h1);
        xfer(1'b0, 8'h08, 32'h0);
        checks++;
        if (r_data !== 32'h0C) begin
            errors++; $display("FAIL or_res1: got %h want 0000000c", r_data);
        end
        checks++;
        if (r_waits !== 1) begin
            errors++; $display("FAIL or_stall: got %0d waits want 1", r_waits);
        end
        checks++;
        if (dcnt[0] - d0 !== 1) begin
            errors++;
            $display("FAIL or_done: got %0d pulses want 1", dcnt[0] - d0);
        end
        xfer(1'b1, 8'h00, 32'hB0);
        xfer(1'b1, 8'h04, 32'h1);
        xfer(1'b0, 8'h04, 32'h0);
        checks++;
        if (r_data !== 32'h0 || r_waits !== 1) begin
            errors++;
            $display("FAIL or_ctrl_stall: got %h waits %0d want 0 waits 1",
                     r_data, r_waits);
        end
        xfer(1'b0, 8'h08, 32'h0);
        checks++;
        if (r_data !== 32'hBC || r_waits !== 0) begin
            errors++;
            $display("FAIL or_res2: got %h waits %0d want 000000bc waits 0",
                     r_data, r_waits);
        end
        xfer(1'b0, 8'h0C, 32'h0);
        checks++;
        if (r_data !== 32'h0) begin
            errors++; $display("FAIL or_stat: got %h want 0", r_data);
        end
    endtask

    task automatic test_errors;
        xfer(1'b1, 8'h08, 32'h55);
        checks++;
        if (r_err !== 1'b1) begin
            errors++; $display("FAIL err_wr_res: got %b want 1", r_err);
        end
        xfer(1'b0, 8'h08, 32'h0);
        checks++;
        if (r_data !== 32'hBC || r_err !== 1'b0) begin
            errors++;
            $display("FAIL err_res_kept: got %h err %b want 000000bc err 0",
                     r_data, r_err);
        end
        xfer(1'b1, 8'h0C, 32'h3);
        checks++;
        if (r_err !== 1'b1) begin
            errors++; $display("FAIL err_wr_stat: got %b want 1", r_err);
        end
        xfer(1'b1, 8'h40, 32'h1);
        checks++;
        if (r_err !== 1'b1) begin
            errors++; $display("FAIL err_wr_ch4: got %b want 1", r_err);
        end
        xfer(1'b0, 8'h40, 32'h0);
        checks++;
        if (r_err !== 1'b1 || r_data !== 32'h0) begin
            errors++;
            $display("FAIL err_rd_ch4: got %h err %b want 0 err 1",
                     r_data, r_err);
        end
        xfer(1'b0, 8'h02, 32'h0);
        checks++;
        if (r_err !== 1'b1 || r_data !== 32'h0) begin
            errors++;
            $display("FAIL err_rd_unal: got %h err %b want 0 err 1",
                     r_data, r_err);
        end
        xfer(1'b1, 8'h01, 32'h77);
        checks++;
        if (r_err !== 1'b1) begin
            errors++; $display("FAIL err_wr_unal: got %b want 1", r_err);
        end
        xfer(1'b0, 8'h00, 32'h0);
        checks++;
        if (r_data !== 32'hB0) begin
            errors++; $display("FAIL err_data_kept: got %h want 000000b0", r_data);
        end
    endtask

    task automatic test_add;
        logic [31:0] exp;
`ifdef APB_ACC_SAT_EN
        exp = 32'hFFFF_FFFF;
`else
        exp = 32'h0000_0001;
`endif
        xfer(1'b1, 8'h10, 32'hFFFF_FFFF);
        xfer(1'b1, 8'h14, 32'hD);
        xfer(1'b0, 8'h18, 32'h0);
        checks++;
        if (r_data !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL add_res1: got %h want ffffffff", r_data);
        end
        xfer(1'b0, 8'h1C, 32'h0);
        checks++;
        if (r_data !== 32'h0) begin
            errors++; $display("FAIL add_stat1: got %h want 0", r_data);
        end
        xfer(1'b1, 8'h10, 32'h2);
        xfer(1'b1, 8'h14, 32'hD);
        xfer(1'b0, 8'h18, 32'h0);
        checks++;
        if (r_data !== exp) begin
            errors++; $display("FAIL add_res2: got %h want %h", r_data, exp);
        end
        xfer(1'b0, 8'h1C, 32'h0);
        checks++;
        if (r_data !== 32'h2) begin
            errors++; $display("FAIL add_ovf: got %h want 00000002", r_data);
        end
        xfer(1'b1, 8'h18, 32'h55);
        xfer(1'b0, 8'h18, 32'h0);
        checks++;
        if (r_data !== exp) begin
            errors++; $display("FAIL add_res_kept: got %h want %h", r_data, exp);
        end
    endtask

    task automatic test_xor_and;
        xfer(1'b1, 8'h20, 32'hF0F0);
        xfer(1'b1, 8'h24, 32'h9);
        xfer(1'b0, 8'h28, 32'h0);
        checks++;
        if (r_data !== 32'hF0F0) begin
            errors++; $display("FAIL xor_res1: got %h want 0000f0f0", r_data);
        end
        xfer(1'b1, 8'h20, 32'hFF00);
        xfer(1'b1, 8'h24, 32'h9);
        xfer(1'b0, 8'h28, 32'h0);
        checks++;
        if (r_data !== 32'h0FF0) begin
            errors++; $display("FAIL xor_res2: got %h want 00000ff0", r_data);
        end
        xfer(1'b1, 8'h20, 32'h0F00);
        xfer(1'b1, 8'h24, 32'h5);
        xfer(1'b0, 8'h28, 32'h0);
        checks++;
        if (r_data !== 32'h0F00) begin
            errors++; $display("FAIL and_res: got %h want 00000f00", r_data);
        end
        xfer(1'b0, 8'h2C, 32'h0);
        checks++;
        if (r_data !== 32'h0) begin
            errors++; $display("FAIL logic_stat: got %h want 0", r_data);
        end
        xfer(1'b0, 8'h24, 32'h0);
        checks++;
        if (r_data !== 32'h4) begin
            errors++; $display("FAIL ctrl_rd: got %h want 00000004", r_data);
        end
    endtask

    task automatic test_busy_data;
        xfer(1'b1, 8'h30, 32'h11);
        xfer(1'b1, 8'h34, 32'h1);
        xfer(1'b1, 8'h30, 32'h22);
        checks++;
        if (r_waits !== 0) begin
            errors++; $display("FAIL data_nostall: got %0d waits want 0", r_waits);
        end
        xfer(1'b0, 8'h38, 32'h0);
        checks++;
        if (r_data !== 32'h11) begin
            errors++; $display("FAIL busy_opnd: got %h want 00000011", r_data);
        end
        xfer(1'b0, 8'h30, 32'h0);
        checks++;
        if (r_data !== 32'h22) begin
            errors++; $display("FAIL busy_data: got %h want 00000022", r_data);
        end
    endtask

    task automatic test_clear;
        int d0;
        d0 = dcnt[0];
        xfer(1'b1, 8'h04, 32'h3);
        repeat (4) @(posedge PCLK);
        #1;
        xfer(1'b0, 8'h08, 32'h0);
        checks++;
        if (r_data !== 32'h0 || r_waits !== 0) begin
            errors++;
            $display("FAIL clr_res: got %h waits %0d want 0 waits 0",
                     r_data, r_waits);
        end
        checks++;
        if (dcnt[0] !== d0) begin
            errors++;
            $display("FAIL clr_done: got %0d pulses want 0", dcnt[0] - d0);
        end
        xfer(1'b0, 8'h04, 32'h0);
        checks++;
        if (r_data !== 32'h0) begin
            errors++; $display("FAIL clr_ctrl: got %h want 0", r_data);
        end
        xfer(1'b0, 8'h0C, 32'h0);
        checks++;
        if (r_data !== 32'h0) begin
            errors++; $display("FAIL clr_stat: got %h want 0", r_data);
        end
        xfer(1'b1, 8'h14, 32'h2);
        xfer(1'b0, 8'h1C, 32'h0);
        checks++;
        if (r_data !== 32'h0) begin
            errors++; $display("FAIL clr_ovf: got %h want 0", r_data);
        end
    endtask

    task automatic test_reset_mid_op;
        int d2;
        int d3;
        d2 = dcnt[2];
        d3 = dcnt[3];
        xfer(1'b1, 8'h24, 32'h1);
        xfer(1'b1, 8'h34, 32'h1);
        PRESETn = 1'b0;
        #1;
        checks++;
        if (done_o !== 4'h0 || PREADY !== 1'b1) begin
            errors++;
            $display("FAIL mid_rst_out: got done %h ready %b want 0 1",
                     done_o, PREADY);
        end
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
        repeat (5) @(posedge PCLK);
        #1;
        xfer(1'b0, 8'h3C, 32'h0);
        checks++;
        if (r_data !== 32'h0) begin
            errors++; $display("FAIL mid_stat3: got %h want 0", r_data);
        end
        xfer(1'b0, 8'h38, 32'h0);
        checks++;
        if (r_data !== 32'h0 || r_waits !== 0) begin
            errors++;
            $display("FAIL mid_res3: got %h waits %0d want 0 waits 0",
                     r_data, r_waits);
        end
        xfer(1'b0, 8'h2C, 32'h0);
        checks++;
        if (r_data !== 32'h0) begin
            errors++; $display("FAIL mid_stat2: got %h want 0", r_data);
        end
        xfer(1'b0, 8'h28, 32'h0);
        checks++;
        if (r_data !== 32'h0) begin
            errors++; $display("FAIL mid_res2: got %h want 0", r_data);
        end
        checks++;
        if (dcnt[2] !== d2 || dcnt[3] !== d3) begin
            errors++;
            $display("FAIL mid_done: got %0d/%0d pulses want 0/0",
                     dcnt[2] - d2, dcnt[3] - d3);
        end
    endtask

    initial begin
        test_reset();
        test_or();
        test_errors();
        test_add();
        test_xor_and();
        test_busy_data();
        test_clear();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_accum_multi.md
Name: apb_accum_multi

Overview:
- Parametrised, multi-channel successor to the single-channel APB OR-accumulator slave.
- Provides NUM_CH independent accumulator channels, each with a DATA, CONTROL, RESULT and STATUS register.
- Each channel supports selectable operations (OR/AND/XOR/ADD) with a configurable operation latency.
- Sits on the peripheral APB bus; signals per-channel completion through done pulses.

Parameters:
- DATA_W, 32, width of PWDATA/PRDATA and of all channel registers
- ADDR_W, 8, width of PADDR
- NUM_CH, 4, number of channels (1..16); channel c occupies base address c*0x10
- OP_LAT, 2, cycles from start acceptance to RESULT update (>=1)

Ports:
- PCLK  in  1  APB clock; single clock domain
- PRESETn  in  1  asynchronous, active-low reset
- PSEL  in  1  APB select
- PENABLE  in  1  APB access phase
- PWRITE  in  1  1=write, 0=read
- PADDR  in  ADDR_W  byte address
- PWDATA  in  DATA_W  write data
- PRDATA  out  DATA_W  read data, valid when PREADY=1 in the access phase
- PREADY  out  1  transfer complete; low inserts wait states
- PSLVERR  out  1  error response, valid with PREADY=1
- done_o  out  NUM_CH  one-cycle pulse per channel when RESULT updates

Behaviour:
- Register map per channel (offset from c*0x10):
  - +0x0 DATA: RW.
  - +0x4 CONTROL: RW. bit0 START, bit1 CLEAR, bits[3:2] OP (00 OR, 01 AND, 10 XOR, 11 ADD). START and CLEAR are self-clearing and read back as 0.
  - +0x8 RESULT: RO.
  - +0xC STATUS: RO. bit0 BUSY, bit1 OVF (sticky). Other bits read 0.
- Reset (PRESETn=0, async): all DATA/RESULT/CONTROL/STATUS=0, PRDATA=0, PREADY=1, PSLVERR=0, done_o=0, any op in flight aborted.
- APB FSM states IDLE -> SETUP (PSEL & !PENABLE) -> ACCESS (PSEL & PENABLE). The transfer completes in ACCESS on the edge where PREADY=1.
- Zero wait states by default. Exception: an access to CONTROL or RESULT of a BUSY channel holds PREADY=0 until that channel's BUSY drops; it then completes in the next cycle with post-update data.
- DATA reads and writes are never stalled.
- CONTROL write with CLEAR=1 (regardless of START): RESULT<=0 and OVF<=0 on the completing edge. No op starts and done_o does not pulse. CLEAR has priority over START.
- CONTROL write with START=1, CLEAR=0:
  - On the completing edge, latch operand=DATA and op=OP, set BUSY, load counter=OP_LAT-1.
  - Counter decrements each cycle. In the cycle it is 0, RESULT <= RESULT op operand, BUSY<=0 and done_o[c] pulses on the following edge.
  - Total: RESULT is visible OP_LAT cycles after acceptance.
- CONTROL write with START=0, CLEAR=0 updates OP only.
- ADD: sum is DATA_W wide and wraps; carry-out sets OVF. OR/AND/XOR never touch OVF.
- DATA written while BUSY does not affect the in-flight op (operand already latched).
- PSLVERR=1 (with PREADY=1, no state change) for:
  - a write to RESULT or STATUS;
  - any access to a channel index >= NUM_CH;
  - PADDR[1:0] != 0.
- Error reads return PRDATA=0.
- Channels are fully independent; several may be BUSY at once.

Optional Feature:
- Macro APB_ACC_SAT_EN.
- Defined: ADD saturates at all-ones on carry-out, and OVF is still set.
- Undefined: ADD wraps modulo 2^DATA_W, and OVF is set.

Decomposition:
- Package apb_accum_pkg holds:
  - op_e enum (OP_OR, OP_AND, OP_XOR, OP_ADD);
  - register offsets (OFF_DATA=0x0, OFF_CTRL=0x4, OFF_RES=0x8, OFF_STAT=0xC) and CH_STRIDE=0x10;
  - CONTROL/STATUS bit positions.
- Sub-module apb_accum_ch: one channel's registers, latency counter, ALU and done pulse. Instantiated NUM_CH times.
- Top level keeps the APB FSM, address decode, error logic and read mux.

Test Plan:
- Reset then read ch0 DATA/CONTROL/RESULT/STATUS -> all 0x00000000, PSLVERR=0; read 0x0C on NUM_CH=4 -> STATUS 0.
- ch0 DATA=0x0C, CONTROL=0x1 (OR), immediate RESULT read -> PREADY low for OP_LAT-1 cycles, returns 0x0C; then DATA=0xB0 START -> 0xBC.
- ch1 DATA=0xFFFFFFFF ADD start, then DATA=0x2 ADD start -> RESULT 0x00000001, STATUS=0x2. With APB_ACC_SAT_EN -> 0xFFFFFFFF, STATUS=0x2.
- ch0 CONTROL=0x3 after RESULT=0xBC -> RESULT 0, no done_o pulse. CONTROL read -> 0x0 (OP=00).
- Write 0x08 (RESULT), write 0x40 (ch4 on NUM_CH=4), read 0x02 (unaligned) -> PSLVERR=1 each, registers unchanged.
- Start ch2 and ch3 in consecutive transfers, assert PRESETn=0 mid-op -> BUSY=0, RESULT=0, no done_o after release.
